alu_serial_ctrl: RTL and testbench

- Multi-cycle, bit-serial N-bit ALU. It processes one operand bit per clock, LSB first, through an internal 1-bit ALU slice datapath (invert, AND/OR/ADD/LESS).
- The slice carry-out is registered and fed back as the next cycle's carry-in.
- A final cycle forms the SLT result and the flags.
- It sits between the core's issue logic and writeback as the area-optimised alternative to a ripple array of 1-bit slices.

---
 rtl/alu_serial_if.sv | 26 ++
 rtl/alu_serial_ctrl.sv | 174 +++++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/alu_serial_if.sv
// Request/response bundle between issue logic and the bit-serial ALU.
// The master drives the operation request; the slave returns status, result and flags.
interface alu_serial_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_ctrl;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             cout;

  modport master (
    output start, a, b, alu_ctrl,
    input  busy, done, result, zero, overflow, cout
  );

  modport slave (
    input  start, a, b, alu_ctrl,
    output busy, done, result, zero, overflow, cout
  );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial N-bit ALU: one operand bit per clock, LSB first, through a 1-bit slice
// with a registered carry; a final cycle forms the SLT result and the flags.
module alu_serial_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic         clk,
  input logic         rst_n,
  alu_serial_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             cin_msb_q, cin_msb_d;
  logic             cout_msb_q, cout_msb_d;
  logic             sum_msb_q, sum_msb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             cout_q, cout_d;

  // 1-bit slice: operates on the LSB of the operand shift registers.
  logic       a_bit, b_bit;
  logic       slice_sum, slice_cout, slice_res;
  logic [1:0] op;

  assign op         = ctrl_q[1:0];
  assign a_bit      = a_q[0] ^ ctrl_q[3];
  assign b_bit      = b_q[0] ^ ctrl_q[2];
  assign slice_sum  = a_bit ^ b_bit ^ carry_q;
  assign slice_cout = (a_bit & b_bit) | (carry_q & (a_bit ^ b_bit));

  always_comb begin
    unique case (op)
      2'd0:    slice_res = a_bit & b_bit;
      2'd1:    slice_res = a_bit | b_bit;
      2'd2:    slice_res = slice_sum;
      default: slice_res = 1'b0;
    endcase
  end

  // Final-cycle result formation.
  logic             ovf_bit;
  logic [WIDTH-1:0] final_res;

  assign ovf_bit   = cin_msb_q ^ cout_msb_q;
  assign final_res = (op == 2'd3) ? {{(WIDTH-1){1'b0}}, sum_msb_q ^ ovf_bit} : shreg_q;

  // NOTE: every _d gets a default hold value first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    ctrl_d     = ctrl_q;
    carry_d    = carry_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    cin_msb_d  = cin_msb_q;
    cout_msb_d = cout_msb_q;
    sum_msb_d  = sum_msb_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    cout_d     = cout_q;

    unique case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          ctrl_d  = bus.alu_ctrl;
          carry_d = bus.alu_ctrl[2];
          shreg_d = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        shreg_d = {slice_res, shreg_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = slice_cout;
        if (idx_q == LAST_IDX) begin
          cin_msb_d  = carry_q;
          cout_msb_d = slice_cout;
          sum_msb_d  = slice_sum;
          state_d    = ST_FINISH;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end

      ST_FINISH: begin
        result_d = final_res;
        zero_d   = (final_res == '0);
        ovf_d    = op[1] & ovf_bit;
        cout_d   = op[1] & cout_msb_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        idx_d    = '0;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  // Datapath registers are reset too: an aborted operation must leave nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      shreg_q    <= '0;
      cin_msb_q  <= 1'b0;
      cout_msb_q <= 1'b0;
      sum_msb_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      cout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ctrl_q     <= ctrl_d;
      carry_q    <= carry_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      cin_msb_q  <= cin_msb_d;
      cout_msb_q <= cout_msb_d;
      sum_msb_q  <= sum_msb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
      cout_q     <= cout_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;
  assign bus.cout     = cout_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl at WIDTH=8: a table of hand-computed vectors
// plus sequences for reset abort, start-while-busy and back-to-back issue.
module tb_alu_serial_ctrl;

  localparam int W   = 8;
  localparam int LAT = W + 1;

  logic clk;
  logic rst_n;

  alu_serial_if #(.WIDTH(W)) bus ();

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         v;
    logic         c;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs[NVEC];

  // Issue one operation, then check latency, result and flags at the done pulse.
  task automatic run_op(input string name, input logic [3:0] ctrl, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_res,
                        input logic exp_z, input logic exp_v, input logic exp_c);
    int lat;
    bit seen;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.alu_ctrl = ctrl;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({name, "_busy"}, 32'(bus.busy), 32'd1);
    check({name, "_done_low"}, 32'(bus.done), 32'd0);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) seen = 1'b1;
    end
    if (!seen) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, "_lat"}, 32'(lat), 32'(LAT));
      check({name, "_res"}, 32'(bus.result), 32'(exp_res));
      check({name, "_zero"}, 32'(bus.zero), 32'(exp_z));
      check({name, "_ovf"}, 32'(bus.overflow), 32'(exp_v));
      check({name, "_cout"}, 32'(bus.cout), 32'(exp_c));
      check({name, "_busy_clr"}, 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    int done_cnt;
    int done_at;
    logic [W-1:0] res_at_done;

    //                ctrl     a      b      res    z     v     c
    vecs[0]  = '{4'b0010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0}; // ADD signed overflow
    vecs[1]  = '{4'b0110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1}; // SUB equal
    vecs[2]  = '{4'b0111, 8'h80, 8'h01, 8'h01, 1'b0, 1'b1, 1'b1}; // SLT -128 < 1
    vecs[3]  = '{4'b0111, 8'h7F, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0}; // SLT 127 < -128 false
    vecs[4]  = '{4'b1100, 8'hF0, 8'h0C, 8'h03, 1'b0, 1'b0, 1'b0}; // NOR
    vecs[5]  = '{4'b0000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0}; // AND
    vecs[6]  = '{4'b0001, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0}; // OR
    vecs[7]  = '{4'b0010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1}; // ADD unsigned wrap
    vecs[8]  = '{4'b0110, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0}; // SUB negative
    vecs[9]  = '{4'b0111, 8'h03, 8'h05, 8'h01, 1'b0, 1'b0, 1'b0}; // SLT 3 < 5
    vecs[10] = '{4'b1101, 8'hF0, 8'h3C, 8'hCF, 1'b0, 1'b0, 1'b0}; // NAND
    vecs[11] = '{4'b0011, 8'h7F, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0}; // op3 carry-in 0
    vecs[12] = '{4'b1010, 8'h05, 8'h03, 8'hFD, 1'b0, 1'b0, 1'b0}; // ~a + b

    bus.start    = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.alu_ctrl = '0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flags", {29'd0, bus.zero, bus.overflow, bus.cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].z, vecs[i].v, vecs[i].c);
    end

    // Reset in the middle of RUN: outputs clear at once and no done appears.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.a        = 8'hF0;
    bus.b        = 8'h3C;
    bus.alu_ctrl = 4'b0001;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_flags", {30'd0, bus.zero, bus.done}, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_op("after_abort", 4'b0010, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 1'b0);

    // start pulsed while busy with different operands: ignored, original result kept.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.a        = 8'h10;
    bus.b        = 8'h20;
    bus.alu_ctrl = 4'b0010;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    done_cnt    = 0;
    done_at     = 0;
    res_at_done = '0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (cyc == 3) begin
        @(negedge clk);
        bus.start    = 1'b1;
        bus.a        = 8'hFF;
        bus.b        = 8'hFF;
        bus.alu_ctrl = 4'b0000;
      end else if (cyc == 4) begin
        @(negedge clk);
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (cyc == 5) begin
        check("held_busy", 32'(bus.busy), 32'd1);
        check("held_result", 32'(bus.result), 32'h33);
      end
      if (bus.done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_at     = cyc;
          res_at_done = bus.result;
        end
      end
    end
    check("busy_start_dones", 32'(done_cnt), 32'd1);
    check("busy_start_lat", 32'(done_at), 32'(LAT));
    check("busy_start_res", 32'(res_at_done), 32'h30);

    // Back-to-back: the second run_op asserts start during the done cycle of the first.
    run_op("b2b_first", 4'b0010, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0);
    run_op("b2b_second", 4'b0110, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
